// File: rtl/cnn_pkg.sv
`default_nettype none
// cnn_pkg: frame constants and sequencer state encoding shared by the UART frame controller.
// Revision: 1.0
package cnn_pkg;

  localparam int         NUM_PIXELS  = 784;
  localparam int         ADDR_W      = 10;
  localparam int         TIMEOUT_CYC = 2_000_000;
  localparam logic [7:0] HDR_BYTE    = 8'hAA;
  localparam logic [7:0] RESULT_OFS  = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_START    = 3'd2,
    ST_WAIT_CNN = 3'd3,
    ST_SEND     = 3'd4,
    ST_TX_WAIT  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_frame_ctrl_if.sv
`default_nettype none
// uart_frame_ctrl_if: UART byte, image buffer and CNN handshakes around the frame sequencer.
// Revision: 1.0
interface uart_frame_ctrl_if #(
  parameter int ADDR_W = 10
) ();

  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              clr_rx_rdy;
  logic              trmt;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic              img_we;
  logic [ADDR_W-1:0] img_addr;
  logic [7:0]        img_wdata;
  logic              cnn_start;
  logic              cnn_done;
  logic [3:0]        cnn_result;
  logic              busy;
  logic              frame_err;

  // Sequencer side.
  modport master (
    input  rx_rdy, rx_data, tx_done, cnn_done, cnn_result,
    output clr_rx_rdy, trmt, tx_data, img_we, img_addr, img_wdata,
           cnn_start, busy, frame_err
  );

  // UART / buffer / CNN side.
  modport slave (
    output rx_rdy, rx_data, tx_done, cnn_done, cnn_result,
    input  clr_rx_rdy, trmt, tx_data, img_we, img_addr, img_wdata,
           cnn_start, busy, frame_err
  );

endinterface
`default_nettype wire

// File: rtl/uart_frame_ctrl_byte_timeout.sv
`default_nettype none
// byte_timeout: idle-cycle counter that flags expiry after TIMEOUT_CYC-1 enabled cycles without a clear.
// Revision: 1.0
module byte_timeout #(
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int              CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_frame_ctrl.sv
`default_nettype none
// uart_frame_ctrl: receives a header-framed image over UART, loads the image buffer,
// runs the CNN and transmits the result byte. Revision: 1.0
module uart_frame_ctrl #(
  parameter int         NUM_PIXELS  = cnn_pkg::NUM_PIXELS,
  parameter int         ADDR_W      = cnn_pkg::ADDR_W,
  parameter int         TIMEOUT_CYC = cnn_pkg::TIMEOUT_CYC,
  parameter logic [7:0] HDR_BYTE    = cnn_pkg::HDR_BYTE,
  parameter logic [7:0] RESULT_OFS  = cnn_pkg::RESULT_OFS
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_frame_ctrl_if.master bus
);

  import cnn_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              cnn_start_q, cnn_start_d;
  logic              trmt_q, trmt_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;
  logic              tx_first_q, tx_first_d;

  logic accept;
  logic take;
  logic tmo_en;
  logic tmo_clr;
  logic tmo_expired;

  // Gated by rst_n so a byte held pending through reset is only consumed after release.
  assign accept  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign take    = rst_n && bus.rx_rdy && accept;
  assign tmo_en  = (state_q == ST_LOAD);
  assign tmo_clr = take || !tmo_en;

  byte_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    tx_data_d   = tx_data_q;
    frame_err_d = frame_err_q;
    tx_first_d  = tx_first_q;
    cnn_start_d = 1'b0;
    trmt_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take && (bus.rx_data == HDR_BYTE)) begin
          state_d     = ST_LOAD;
          pix_d       = '0;
          frame_err_d = 1'b0;
        end
      end
      ST_LOAD: begin
        // A byte arriving on the expiry cycle takes priority over the abort.
        if (take) begin
          pix_d = pix_q + 1'b1;
          if (pix_q == LAST_ADDR) begin
            state_d     = ST_START;
            cnn_start_d = 1'b1;
          end
        end else if (tmo_expired) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_CNN;
      end
      ST_WAIT_CNN: begin
        if (bus.cnn_done) begin
          tx_data_d = RESULT_OFS + {4'h0, bus.cnn_result};
          state_d   = ST_SEND;
          trmt_d    = 1'b1;
        end
      end
      ST_SEND: begin
        state_d    = ST_TX_WAIT;
        tx_first_d = 1'b1;
      end
      ST_TX_WAIT: begin
        // tx_done is still high from the previous transfer on the first cycle here.
        tx_first_d = 1'b0;
        if (!tx_first_q && bus.tx_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pix_q       <= '0;
      tx_data_q   <= 8'h00;
      cnn_start_q <= 1'b0;
      trmt_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      tx_first_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      tx_data_q   <= tx_data_d;
      cnn_start_q <= cnn_start_d;
      trmt_q      <= trmt_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      tx_first_q  <= tx_first_d;
    end
  end

  assign bus.clr_rx_rdy = take;
  assign bus.img_we     = take && (state_q == ST_LOAD);
  assign bus.img_addr   = pix_q;
  assign bus.img_wdata  = bus.rx_data;
  assign bus.cnn_start  = cnn_start_q;
  assign bus.trmt       = trmt_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.busy       = busy_q;
  assign bus.frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_ctrl.sv
`default_nettype none
// tb_uart_frame_ctrl: randomized frames against a byte-stream reference model with a scoreboard monitor.
// Revision: 1.0
module tb_uart_frame_ctrl;

  localparam int TMO    = 64;
  localparam int NPIX   = 784;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  uart_frame_ctrl #(
    .NUM_PIXELS  (NPIX),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TMO),
    .HDR_BYTE    (8'hAA),
    .RESULT_OFS  (8'h30)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard state.
  logic [17:0] exp_wr[$];
  logic [7:0]  exp_tx[$];
  int          exp_starts = 0;
  logic [7:0]  last_tx = 8'h00;
  int          n_start = 0, n_trmt = 0, n_txdone = 0, n_clr = 0, n_sent = 0;
  logic        last_take_busy = 1'b0;
  bit          first_cnn = 1'b1;

  // Reference model: the frame parser seen as an ordered byte stream.
  bit m_loading = 1'b0;
  int m_cnt     = 0;
  bit m_err     = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // offset = cycles from the previous consumed byte to this byte's arrival.
  task automatic model_gap(input int offset);
    if (m_loading && offset > TMO) begin
      m_loading = 1'b0;
      m_err     = 1'b1;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [9:0] a;
    if (!m_loading) begin
      if (b == 8'hAA) begin
        m_loading = 1'b1;
        m_cnt     = 0;
        m_err     = 1'b0;
      end
    end else begin
      a = 10'(m_cnt);
      exp_wr.push_back({a, b});
      m_cnt++;
      if (m_cnt == NPIX) begin
        m_loading = 1'b0;
        exp_starts++;
      end
    end
  endtask

  task automatic wait_consume();
    int n = 0;
    forever begin
      @(negedge clk);
      if (bus.clr_rx_rdy) break;
      n++;
      if (n > 5000) begin
        check("rx_consume_timeout", n, 5000);
        break;
      end
    end
    last_take_busy = bus.busy;
    @(posedge clk);
    #1 bus.rx_rdy = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap + 1) begin
      @(posedge clk);
      #1;
    end
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    model_gap(gap + 2);
    model_byte(b);
    n_sent++;
    wait_consume();
  endtask

  // Monitor: pops expectations whenever the DUT presents an output event.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.clr_rx_rdy) n_clr++;
        if (bus.img_we) begin
          check("img_we_expected", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            check("img_addr", 32'(bus.img_addr), 32'(e[17:8]));
            check("img_wdata", bus.img_wdata, e[7:0]);
          end
        end
        if (bus.cnn_start) begin
          n_start++;
          check("cnn_start_expected", exp_starts > 0, 1);
          check("writes_before_start", exp_wr.size(), 0);
          if (exp_starts > 0) exp_starts--;
        end
        if (bus.trmt) begin
          n_trmt++;
          check("trmt_expected", exp_tx.size() > 0, 1);
          if (exp_tx.size() > 0) begin
            last_tx = exp_tx.pop_front();
            check("tx_data", bus.tx_data, last_tx);
          end
        end
      end
    end
  end

  // CNN model: random latency and class, one-cycle done pulse.
  initial begin
    int dly;
    int res;
    logic [7:0] r8;
    bus.cnn_done   = 1'b0;
    bus.cnn_result = 4'h0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.cnn_start) begin
        dly = first_cnn ? 3 : $urandom_range(1, 25);
        res = first_cnn ? 7 : $urandom_range(0, 9);
        first_cnn = 1'b0;
        repeat (dly) begin
          @(posedge clk);
          #1;
        end
        bus.cnn_done   = 1'b1;
        bus.cnn_result = 4'(res);
        r8 = 8'(res);
        exp_tx.push_back(8'h30 + r8);
        @(posedge clk);
        #1;
        bus.cnn_done   = 1'b0;
        bus.cnn_result = 4'($urandom_range(10, 15));
      end
    end
  end

  // UART TX model: tx_done stays stale-high on the first cycle after trmt.
  initial begin
    int dly;
    bus.tx_done = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && bus.trmt) begin
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 bus.tx_done = 1'b0;
        @(negedge clk);
        check("busy_ignores_stale_tx_done", bus.busy, 1);
        dly = $urandom_range(1, 6);
        repeat (dly) begin
          @(posedge clk);
          #1;
        end
        bus.tx_done = 1'b1;
        @(negedge clk);
        check("tx_data_hold", bus.tx_data, last_tx);
        check("busy_at_tx_done", bus.busy, 1);
        @(negedge clk);
        check("busy_after_tx_done", bus.busy, 0);
        n_txdone++;
      end
    end
  end

  initial begin
    logic [7:0] b;
    int         wait_n;
    rst_n       = 1'b0;
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'h55;

    #2;
    check("rst_clr_rx_rdy", bus.clr_rx_rdy, 0);
    check("rst_img_we", bus.img_we, 0);
    check("rst_cnn_start", bus.cnn_start, 0);
    check("rst_trmt", bus.trmt, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_tx_data", bus.tx_data, 0);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_no_consume", bus.clr_rx_rdy, 0);
    end

    // Pending byte through reset is consumed once under IDLE rules.
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_byte(8'h55);
    n_sent++;
    wait_consume();
    repeat (8) @(posedge clk);
    #1;
    check("rst_pending_single_clr", n_clr, 1);
    check("rst_pending_busy", bus.busy, 0);

    // Frame A: junk, header, ramp pixels (includes 0xAA as data).
    send(8'h55, 1);
    send(8'hAA, 1);
    for (int i = 0; i < NPIX; i++) begin
      b = 8'(i);
      send(b, $urandom_range(0, 2));
    end
    // Header sent while the CNN is busy must wait for IDLE.
    send(8'hAA, 0);
    check("pending_consumed_in_idle", last_take_busy, 0);
    check("pending_after_trmt", n_trmt, 1);
    check("frame_a_err", bus.frame_err, m_err);

    // Frame B: random pixels with forced header values inside LOAD.
    for (int i = 0; i < NPIX; i++) begin
      b = (i % 97 == 5) ? 8'hAA : 8'($urandom_range(0, 255));
      send(b, $urandom_range(0, 2));
    end

    // Frame C: 100 pixels then one cycle past the timeout.
    send(8'hAA, 1);
    for (int i = 0; i < 100; i++) begin
      b = 8'($urandom_range(0, 255));
      send(b, $urandom_range(0, 2));
    end
    send(8'h11, TMO - 1);
    check("timeout_frame_err", bus.frame_err, m_err);
    check("timeout_model_err", m_err, 1);
    check("timeout_busy", bus.busy, 0);
    check("timeout_take_in_idle", last_take_busy, 0);

    // Frame D: header clears the error; one gap exactly at the expiry cycle.
    send(8'hAA, 2);
    check("hdr_clears_frame_err", bus.frame_err, 0);
    for (int i = 0; i < NPIX; i++) begin
      b = 8'($urandom_range(0, 255));
      send(b, (i == 50) ? TMO - 2 : $urandom_range(0, 2));
    end

    wait_n = 0;
    while (n_txdone < 3 && wait_n < 5000) begin
      @(posedge clk);
      wait_n++;
    end
    #1;
    check("final_tx_done_count", n_txdone, 3);
    check("final_cnn_starts", n_start, 3);
    check("final_trmt_count", n_trmt, 3);
    check("final_writes_left", exp_wr.size(), 0);
    check("final_starts_left", exp_starts, 0);
    check("final_tx_left", exp_tx.size(), 0);
    check("final_clr_count", n_clr, n_sent);
    check("final_frame_err", bus.frame_err, m_err);
    check("final_busy", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
